// File: rtl/booth_mac_accum.sv
// Framed multiply-accumulate behind the Booth multiplier core.
// Completed sums are queued in a small result FIFO with ready/valid output.
module booth_mac_accum #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_in,
  input  logic [15:0]      p_in,
  input  logic             p_sgn,
  input  logic             first,
  input  logic             last,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [ACC_W-1:0] r_data,
  output logic [CNT_W-1:0] r_cnt,
  output logic             r_ovf,
  output logic [AW:0]      fifo_level,
  output logic             drop,
  output logic             err_abort
);

  localparam int EW = ACC_W + CNT_W + 1;

  logic [ACC_W-1:0] acc, acc_n, term;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n, active, fresh;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop, wr_en;

  always_comb begin
    term  = p_sgn ? {{(ACC_W-16){p_in[15]}}, p_in}
                  : {{(ACC_W-16){1'b0}}, p_in};
    fresh = first | ~active;
    acc_n = term;
    cnt_n = CNT_W'(1);
    ovf_n = 1'b0;
    if (!fresh) begin
      acc_n = acc + term;
      cnt_n = (&cnt) ? cnt : cnt + 1'b1;
      ovf_n = ovf | ((acc[ACC_W-1] == term[ACC_W-1]) &&
                     (acc_n[ACC_W-1] != acc[ACC_W-1]));
    end
  end

  // Extra pointer bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = v_in & last;
  assign pop   = r_valid & r_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      active    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      drop      <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      if (v_in) begin
        acc    <= acc_n;
        cnt    <= cnt_n;
        ovf    <= ovf_n;
        active <= ~last;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      drop      <= push & full & ~pop;
      err_abort <= v_in & first & active;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {acc_n, cnt_n, ovf_n};
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign r_valid    = ~empty;
  assign fifo_level = wr_ptr - rd_ptr;
  assign r_data     = r_valid ? head[EW-1 -: ACC_W] : '0;
  assign r_cnt      = r_valid ? head[CNT_W:1] : '0;
  assign r_ovf      = r_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Bench for booth_mac_accum: 32-bit and 17-bit accumulators side by side,
// checked every cycle against an arithmetic model plus literal expectations.
module tb_booth_mac_accum;

  logic        clk = 0;
  logic        rst, v_in, p_sgn, first, last, r_ready;
  logic [15:0] p_in;

  logic        rv0, ov0, dr0, ab0;
  logic [31:0] rd0;
  logic [15:0] rc0;
  logic [2:0]  lv0;
  logic        rv1, ov1, dr1, ab1;
  logic [16:0] rd1;
  logic [15:0] rc1;
  logic [2:0]  lv1;

  booth_mac_accum #(.ACC_W(32), .CNT_W(16), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .v_in(v_in), .p_in(p_in), .p_sgn(p_sgn),
    .first(first), .last(last), .r_valid(rv0), .r_ready(r_ready),
    .r_data(rd0), .r_cnt(rc0), .r_ovf(ov0), .fifo_level(lv0),
    .drop(dr0), .err_abort(ab0)
  );

  booth_mac_accum #(.ACC_W(17), .CNT_W(16), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .v_in(v_in), .p_in(p_in), .p_sgn(p_sgn),
    .first(first), .last(last), .r_valid(rv1), .r_ready(r_ready),
    .r_data(rd1), .r_cnt(rc1), .r_ovf(ov1), .fifo_level(lv1),
    .drop(dr1), .err_abort(ab1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: exact signed sums, queue of completed frames.
  typedef struct {
    longint unsigned d [2];
    bit              o [2];
    int              c;
  } ent_t;

  ent_t            q[$];
  longint unsigned m_acc [2];
  bit              m_ovf [2];
  int              m_cnt;
  bit              m_active, m_drop, m_abort;
  int              wid [2] = '{32, 17};

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_acc = '{0, 0};
      m_ovf = '{0, 0};
      m_cnt = 0;
      m_active = 0;
      m_drop = 0;
      m_abort = 0;
    end else begin
      bit pop_now, push_now;
      pop_now  = r_ready && (q.size() > 0);
      push_now = v_in && last;
      m_abort  = v_in && first && m_active;
      if (v_in) begin
        longint tv;
        tv = p_sgn ? longint'($signed(p_in)) : longint'(p_in);
        for (int k = 0; k < 2; k++) begin
          longint unsigned mask;
          longint cur, s, lo, hi;
          mask = (longint'(1) << wid[k]) - 1;
          lo = -(longint'(1) << (wid[k] - 1));
          hi = (longint'(1) << (wid[k] - 1)) - 1;
          if (first || !m_active) begin
            m_acc[k] = longint'(tv) & mask;
            m_ovf[k] = 0;
          end else begin
            cur = m_acc[k][wid[k]-1] ? longint'(m_acc[k]) - (longint'(1) << wid[k])
                                     : longint'(m_acc[k]);
            s = cur + tv;
            if (s < lo || s > hi) m_ovf[k] = 1;
            m_acc[k] = longint'(s) & mask;
          end
        end
        if (first || !m_active) m_cnt = 1;
        else if (m_cnt < 65535) m_cnt++;
        m_active = !last;
      end
      m_drop = push_now && (q.size() == 4) && !pop_now;
      if (pop_now) void'(q.pop_front());
      if (push_now && q.size() < 4) begin
        ent_t e;
        e.d = m_acc;
        e.o = m_ovf;
        e.c = m_cnt;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit hv;
      hv = q.size() > 0;
      chk("r_valid0", rv0, hv);
      chk("r_data0", rd0, hv ? q[0].d[0] : 0);
      chk("r_cnt0", rc0, hv ? q[0].c : 0);
      chk("r_ovf0", ov0, hv ? q[0].o[0] : 0);
      chk("level0", lv0, q.size());
      chk("drop0", dr0, m_drop);
      chk("abort0", ab0, m_abort);
      chk("r_valid1", rv1, hv);
      chk("r_data1", rd1, hv ? q[0].d[1] : 0);
      chk("r_cnt1", rc1, hv ? q[0].c : 0);
      chk("r_ovf1", ov1, hv ? q[0].o[1] : 0);
      chk("level1", lv1, q.size());
      chk("drop1", dr1, m_drop);
      chk("abort1", ab1, m_abort);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] p, input logic s,
                      input logic f, input logic l);
    v_in = 1; p_in = p; p_sgn = s; first = f; last = l;
    step();
    v_in = 0; p_in = 0; p_sgn = 0; first = 0; last = 0;
  endtask

  initial begin
    rst = 1; v_in = 0; p_in = 0; p_sgn = 0;
    first = 0; last = 0; r_ready = 0;
    step();
    step();
    started = 1;
    rst = 0;
    chk("rst_valid", rv0, 0);
    chk("rst_level", lv0, 0);

    // reset mid-frame
    beat(16'h0010, 0, 1, 0);
    rst = 1;
    step();
    step();
    rst = 0;
    chk("midrst_valid", rv0, 0);
    chk("midrst_level", lv0, 0);
    beat(16'h0003, 0, 0, 1);
    chk("orphan_data", rd0, 32'h00000003);
    chk("orphan_cnt", rc0, 1);
    r_ready = 1;
    step();
    r_ready = 0;

    // unsigned frame
    beat(16'hFFFF, 0, 1, 0);
    beat(16'hFFFF, 0, 0, 0);
    beat(16'h0001, 0, 0, 1);
    chk("uns_valid", rv0, 1);
    chk("uns_data", rd0, 32'h0001FFFF);
    chk("uns_cnt", rc0, 3);
    chk("uns_ovf", ov0, 0);
    r_ready = 1;
    step();
    chk("uns_level", lv0, 0);
    r_ready = 0;

    // signed frame
    beat(16'hFF38, 1, 1, 0);
    beat(16'h0064, 1, 0, 1);
    chk("sgn_data", rd0, 32'hFFFFFF9C);
    chk("sgn_cnt", rc0, 2);
    chk("sgn_ovf", ov0, 0);
    r_ready = 1;
    step();
    r_ready = 0;

    // overflow on the 17-bit instance
    beat(16'h7FFF, 1, 1, 0);
    beat(16'h7FFF, 1, 0, 0);
    beat(16'h7FFF, 1, 0, 1);
    chk("ovf_data17", rd1, 17'h17FFD);
    chk("ovf_flag17", ov1, 1);
    chk("ovf_cnt17", rc1, 3);
    chk("ovf_flag32", ov0, 0);
    r_ready = 1;
    step();
    r_ready = 0;

    // backpressure: five single-beat frames into four entries
    for (int i = 1; i <= 5; i++) beat(16'(i), 0, 1, 1);
    chk("full_level", lv0, 4);
    chk("full_drop", dr0, 1);
    chk("full_head", rd0, 1);
    step();
    chk("drop_once", dr0, 0);
    r_ready = 1;
    beat(16'h0006, 0, 1, 1);
    chk("pushpop_level", lv0, 4);
    chk("pushpop_drop", dr0, 0);
    chk("pushpop_head", rd0, 2);
    step();
    chk("drain_3", rd0, 3);
    step();
    chk("drain_4", rd0, 4);
    step();
    chk("drain_6", rd0, 6);
    step();
    chk("drain_empty", rv0, 0);
    r_ready = 0;

    // abort by a new first
    beat(16'h0005, 0, 1, 0);
    beat(16'h0007, 0, 1, 1);
    chk("abort_pulse", ab0, 1);
    chk("abort_data", rd0, 32'h00000007);
    chk("abort_cnt", rc0, 1);
    step();
    chk("abort_once", ab0, 0);
    r_ready = 1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mac_accum.md
Name: booth_mac_accum

Overview:
- Downstream consumer of the 8-bit Booth multiplier core. It takes the core's product stream (16-bit product plus valid) and accumulates products into framed multiply-accumulate results.
- Frames are delimited by first/last markers that upstream logic delays alongside the core pipeline.
- The core has no backpressure, so completed results are buffered in a small FIFO. Results leave through a ready/valid interface.

Parameters:
- ACC_W, 32, accumulator and result width (min 17).
- CNT_W, 16, term-counter width; counter saturates at all-ones.
- FIFO_DEPTH, 4, result FIFO entries (power of two, min 2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- v_in  in  1  product valid (core v_out).
- p_in  in  16  product (core p).
- p_sgn  in  1  product is signed (operand mode was not unsigned×unsigned); aligned with v_in.
- first  in  1  beat starts a frame; qualified by v_in.
- last  in  1  beat ends a frame; qualified by v_in.
- r_valid  out  1  result available at FIFO head.
- r_ready  in  1  consumer accepts result.
- r_data  out  ACC_W  accumulated sum at head.
- r_cnt  out  CNT_W  number of terms in the head result.
- r_ovf  out  1  head result overflowed.
- fifo_level  out  log2(FIFO_DEPTH)+1  entries held.
- drop  out  1  one-cycle pulse: completed result lost, FIFO full.
- err_abort  out  1  one-cycle pulse: open frame discarded by a new first.

Behaviour:
- Reset (rst=1 at posedge): acc=0, cnt=0, ovf=0, active=0, FIFO emptied, r_valid=0, fifo_level=0, drop=0, err_abort=0. Reset mid-frame discards the partial frame with no pulse.
- Term extension: term = p_sgn ? sign-extend(p_in) : zero-extend(p_in) to ACC_W.
- Accumulator update on v_in=1:
  - If first=1 or active=0: acc_n=term, cnt_n=1, ovf_n=0.
  - Otherwise: acc_n=acc+term (mod 2^ACC_W), cnt_n=sat(cnt+1).
  - ovf_n=ovf | (MSB(acc)==MSB(term) && MSB(acc_n)!=MSB(acc)).
  - acc/cnt/ovf take the _n values. active<=~last.
- Abort: v_in&first&~last while active=1, or v_in&first&last while active=1, pulses err_abort the next cycle. The old partial sum is discarded and the new frame starts.
- Orphan beat: v_in with active=0 and first=0 is treated as an implicit first (no error).
- v_in=0: all accumulator state holds; first/last are ignored.
- Push: on v_in&last, {acc_n, cnt_n, ovf_n} is written to the FIFO at that edge.
  - r_valid rises the following cycle (1-cycle latency from the last beat).
  - first&last on one beat is a single-term frame.
- Pop: on a posedge with r_valid&r_ready, the head advances.
- Outputs r_data/r_cnt/r_ovf show the head entry and are 0 when r_valid=0.
- Full rules:
  - Push while full and no pop: entry dropped, drop pulses the next cycle, FIFO unchanged.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no drop.
  - Push and pop when empty: not possible in the same cycle (no fall-through); the push lands and the level becomes 1.
- fifo_level = pushes − pops. Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Accumulation never stalls: v_in is accepted every cycle regardless of FIFO state.
- Ordering: results emerge in frame-completion order.

Test Plan:
- Reset: drive rst=1 for 2 cycles mid-frame (after p_in=0x0010 first) → r_valid=0, fifo_level=0. A next beat p_in=0x0003 with last only → r_data=0x00000003, r_cnt=1.
- Unsigned frame: p_sgn=0, beats 0xFFFF(first), 0xFFFF, 0x0001(last) → one cycle later r_valid=1, r_data=0x0001FFFF, r_cnt=3, r_ovf=0. With r_ready=1, the level returns to 0.
- Signed frame: p_sgn=1, beats 0xFF38(first, −200), 0x0064(last, +100) → r_data=0xFFFFFF9C, r_cnt=2, r_ovf=0.
- Overflow (ACC_W=17): p_sgn=1, three beats 0x7FFF, first on beat 1, last on beat 3 → r_data=0x17FFD, r_ovf=1, r_cnt=3.
- Backpressure (FIFO_DEPTH=4): r_ready=0, five back-to-back single-beat frames with values 1..5 → fifo_level=4 and drop pulses once after the 5th. Then r_ready=1 → r_data 1,2,3,4 in order. Also check full with simultaneous push/pop gives no drop.
- Abort: beat 0x0005 first, then beat 0x0007 first&last → err_abort pulses once; result r_data=0x00000007, r_cnt=1.
